// File: rtl/sw_edge_irq_ctrl.sv
// Slide-switch controller: sync + optional debounce (SW_DEBOUNCE_EN), edge capture, maskable irq,
// 4-word Avalon-MM slave with read latency 1.
`ifdef SW_DEBOUNCE_EN
module sw_debounce_bit #(
   parameter int DEBOUNCE_CYCLES = 50000,
   parameter int CNT_W           = 16
) (
   input  logic clk,
   input  logic reset,
   input  logic raw,
   output logic stable
);
   typedef enum logic {IDLE, COUNT} state_t;

   // The IDLE->COUNT cycle already counts as the first stable cycle.
   localparam logic [CNT_W-1:0] TERM = CNT_W'(DEBOUNCE_CYCLES - 1);

   state_t           state;
   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state  <= IDLE;
         cnt    <= '0;
         stable <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               cnt <= '0;
               if (raw != stable) begin
                  if (TERM == '0) begin
                     stable <= raw;
                  end else begin
                     cnt   <= CNT_W'(1);
                     state <= COUNT;
                  end
               end
            end
            COUNT: begin
               if (raw == stable) begin
                  state <= IDLE;
                  cnt   <= '0;
               end else if (cnt == TERM) begin
                  stable <= raw;
                  state  <= IDLE;
                  cnt    <= '0;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            default: begin
               state <= IDLE;
               cnt   <= '0;
            end
         endcase
      end
   end
endmodule
`endif

module sw_edge_irq_ctrl #(
   parameter int WIDTH           = 2,
   parameter int DEBOUNCE_CYCLES = 50000,
   parameter int CNT_W           = 16,
   parameter int EDGE_TYPE       = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [1:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   input  logic [WIDTH-1:0] in_port,
   output logic [31:0]      readdata,
   output logic             irq
);
   logic [WIDTH-1:0] sync1, raw_sync, stable, stable_d;
   logic [WIDTH-1:0] mask, edgecapture;
   logic [WIDTH-1:0] rise, fall, edge_evt, clr;
   logic [31:0]      rd_mux;
   logic             wr_en;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1    <= '0;
         raw_sync <= '0;
      end else begin
         sync1    <= in_port;
         raw_sync <= sync1;
      end
   end

`ifdef SW_DEBOUNCE_EN
   for (genvar i = 0; i < WIDTH; i++) begin : g_db
      sw_debounce_bit #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
         .CNT_W          (CNT_W)
      ) u_db (
         .clk   (clk),
         .reset (reset),
         .raw   (raw_sync[i]),
         .stable(stable[i])
      );
   end
`else
   logic [CNT_W-1:0] unused_db;
   assign unused_db = CNT_W'(DEBOUNCE_CYCLES);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) stable <= '0;
      else       stable <= raw_sync;
   end
`endif

   assign rise = stable & ~stable_d;
   assign fall = ~stable & stable_d;

   always_comb begin
      case (EDGE_TYPE)
         0:       edge_evt = rise;
         1:       edge_evt = fall;
         default: edge_evt = rise | fall;
      endcase
   end

   assign wr_en = chipselect & ~write_n;
   assign clr   = (wr_en && address == 2'd3) ? writedata[WIDTH-1:0] : '0;

   always_comb begin
      rd_mux = '0;
      case (address)
         2'd0: rd_mux[WIDTH-1:0] = stable;
         2'd1: rd_mux[WIDTH-1:0] = raw_sync;
         2'd2: rd_mux[WIDTH-1:0] = mask;
         2'd3: rd_mux[WIDTH-1:0] = edgecapture;
         default: rd_mux = '0;
      endcase
   end

   logic unused_wdata;
   assign unused_wdata = ^writedata[31:WIDTH];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stable_d    <= '0;
         mask        <= '0;
         edgecapture <= '0;
         irq         <= 1'b0;
         readdata    <= '0;
      end else begin
         stable_d <= stable;
         if (wr_en && address == 2'd2) mask <= writedata[WIDTH-1:0];
         // OR-ing the new edges after the clear lets a same-cycle set win.
         edgecapture <= (edgecapture & ~clr) | edge_evt;
         irq         <= |(edgecapture & mask);
         readdata    <= rd_mux;
      end
   end
endmodule
